// File: rtl/serial_endpoint.sv
// serial_endpoint: 8N1 UART bridging a processor's serial MMIO port.
// Bytes written by the processor queue in a TX FIFO and are shifted out
// on uart_tx_out. Bytes received on uart_rx_in queue in an RX FIFO that
// the processor drains. Overrun and framing errors are kept as sticky flags.
//
// Handshake: a push or pop happens on a rising edge where the strobe
// (proc_wren_in / proc_rden_in / internal push) is high and the FIFO's
// ready/valid, derived only from the registered occupancy count, is high.
// Strobes on any other edge are ignored. A push into a full FIFO is also
// taken when the same edge pops that FIFO.
module serial_endpoint #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_data_in,
    input  logic       proc_wren_in,
    output logic       proc_ready_out,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    input  logic       proc_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out,
    input  logic       clear_err_in,
    output logic [1:0] tx_state,
    output logic [1:0] rx_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd;
    logic [CW-1:0] tx_count;
    logic          tx_push, tx_pop;

    assign proc_ready_out = (tx_count != FULL_CNT);
    assign tx_push        = proc_wren_in && (proc_ready_out || tx_pop);

    // TX FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr] <= proc_data_in;
    end

    // ---------------- TX FSM ----------------
    uart_state_e tx_st, tx_nx;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    assign tx_tick  = (tx_cnt == BIT_LAST);
    assign tx_state = tx_st;

    // TX next state; the FIFO head is popped on the IDLE->START edge
    always_comb begin
        tx_nx  = tx_st;
        tx_pop = 1'b0;
        case (tx_st)
            S_IDLE: begin
                if (tx_count != '0) begin
                    tx_nx  = S_START;
                    tx_pop = 1'b1;
                end
            end
            S_START: if (tx_tick) tx_nx = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nx = S_STOP;
            S_STOP:  if (tx_tick) tx_nx = S_IDLE;
            default: tx_nx = S_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_st <= S_IDLE;
        else        tx_st <= tx_nx;
    end

    // TX bit timer, shifter and registered line driver
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            if (tx_st == S_IDLE || tx_nx != tx_st || tx_tick) tx_cnt <= '0;
            else                                              tx_cnt <= tx_cnt + 16'd1;
            case (tx_st)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_shift    <= tx_mem[tx_rd];
                        tx_bit      <= '0;
                        uart_tx_out <= 1'b0;
                    end
                end
                S_START: if (tx_tick) uart_tx_out <= tx_shift[0];
                S_DATA: begin
                    if (tx_tick) begin
                        tx_bit      <= tx_bit + 3'd1;
                        tx_shift    <= {1'b0, tx_shift[7:1]};
                        uart_tx_out <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                    end
                end
                default: uart_tx_out <= 1'b1;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_meta, rx_sync;

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_in;
            rx_sync <= rx_meta;
        end
    end

    uart_state_e rx_st, rx_nx;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_hold;
    logic        rx_tick, rx_done;
    logic        rx_push, rx_pop, overrun_evt, frame_evt;

    assign rx_state = rx_st;

    // RX next state; START re-checks the line half a bit in to reject glitches
    always_comb begin
        rx_nx   = rx_st;
        rx_tick = 1'b0;
        rx_done = 1'b0;
        case (rx_st)
            S_IDLE: if (!rx_hold && !rx_sync) rx_nx = S_START;
            S_START: begin
                rx_tick = (rx_cnt == HALF_LAST);
                if (rx_tick) rx_nx = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                rx_tick = (rx_cnt == BIT_LAST);
                if (rx_tick && rx_bit == 3'd7) rx_nx = S_STOP;
            end
            S_STOP: begin
                rx_tick = (rx_cnt == BIT_LAST);
                if (rx_tick) begin
                    rx_nx   = S_IDLE;
                    rx_done = 1'b1;
                end
            end
            default: rx_nx = S_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_st <= S_IDLE;
        else        rx_st <= rx_nx;
    end

    // RX bit timer, shifter, and post-framing-error line-high wait
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_hold  <= 1'b0;
        end else begin
            if (rx_st == S_IDLE || rx_nx != rx_st || rx_tick) rx_cnt <= '0;
            else                                              rx_cnt <= rx_cnt + 16'd1;
            if (rx_st == S_IDLE) rx_bit <= '0;
            if (rx_st == S_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
            if (frame_evt)                            rx_hold <= 1'b1;
            else if (rx_st == S_IDLE && rx_sync)      rx_hold <= 1'b0;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr, rx_rd;
    logic [CW-1:0] rx_count;

    assign proc_valid_out = (rx_count != '0);
    assign proc_data_out  = proc_valid_out ? rx_mem[rx_rd] : 8'h00;
    assign rx_pop         = proc_rden_in && proc_valid_out;
    assign rx_push        = rx_done && rx_sync && ((rx_count != FULL_CNT) || rx_pop);
    assign overrun_evt    = rx_done && rx_sync && !rx_push;
    assign frame_evt      = rx_done && !rx_sync;

    // RX FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr] <= rx_shift;
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_overrun_out   <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            if (overrun_evt)       rx_overrun_out <= 1'b1;
            else if (clear_err_in) rx_overrun_out <= 1'b0;
            if (frame_evt)         rx_frame_err_out <= 1'b1;
            else if (clear_err_in) rx_frame_err_out <= 1'b0;
        end
    end

endmodule

// File: doc/serial_endpoint.md
SERIAL_ENDPOINT -- requirements
Module: serial_endpoint

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries in each of the TX and RX FIFOs (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port proc_data_in  input  8  byte written by the processor's serial MMIO.
REQ-006 SHALL have port proc_wren_in  input  1  one-cycle write strobe that pushes proc_data_in.
REQ-007 SHALL have port proc_ready_out  output  1  TX FIFO not full; drives the processor's serial ready input.
REQ-008 SHALL have port proc_data_out  output  8  head of the RX FIFO; drives the processor's serial data input.
REQ-009 SHALL have port proc_valid_out  output  1  RX FIFO not empty; drives the processor's serial valid input.
REQ-010 SHALL have port proc_rden_in  input  1  one-cycle read strobe that pops the RX head.
REQ-011 SHALL have port uart_rx_in  input  1  asynchronous serial line in; idles high.
REQ-012 SHALL have port uart_tx_out  output  1  serial line out; idles high.
REQ-013 SHALL have port rx_overrun_out  output  1  sticky flag: a received byte was dropped because the RX FIFO was full.
REQ-014 SHALL have port rx_frame_err_out  output  1  sticky flag: a stop bit was sampled low.
REQ-015 SHALL have port clear_err_in  input  1  one-cycle pulse that clears both sticky flags.

Function
REQ-016 Framing SHALL be 8N1: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 TX push: proc_wren_in=1 with proc_ready_out=1 SHALL enqueue proc_data_in on that edge; proc_wren_in while full SHALL be ignored, with no state change.
REQ-018 The TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on the first edge with the TX FIFO non-empty, popping the head into the shift register on that edge.
REQ-019 uart_tx_out SHALL be registered; start-bit low SHALL appear the cycle after the IDLE->START edge.
REQ-020 START->DATA, DATA (after 8 bits)->STOP, and STOP->IDLE SHALL each occur after CLKS_PER_BIT cycles; STOP->IDLE->START back-to-back SHALL add no idle bit time beyond the one IDLE cycle.
REQ-021 uart_rx_in SHALL pass through a two-flop synchronizer before any use.
REQ-022 The RX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START when the synchronized input is 0.
REQ-023 In START, the line SHALL be re-sampled after CLKS_PER_BIT/2 (integer division) cycles: if 0 go to DATA, else return to IDLE with nothing pushed (glitch rejection).
REQ-024 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals (mid-bit); STOP SHALL sample once CLKS_PER_BIT later, then return to IDLE.
REQ-025 If the stop bit is 1 and the RX FIFO is not full, the byte SHALL be pushed.
REQ-026 If the stop bit is 1 and the RX FIFO is full, the byte SHALL be dropped and rx_overrun_out set.
REQ-027 If the stop bit is 0, the byte SHALL be discarded and rx_frame_err_out set; the FSM SHALL then wait in IDLE until the line has been 1 for at least one cycle.
REQ-028 RX pop: proc_rden_in=1 with proc_valid_out=1 SHALL advance the head; proc_rden_in while empty SHALL be ignored.
REQ-029 proc_data_out SHALL be stable while proc_valid_out=1 and there is no pop.
REQ-030 Simultaneous pop and push on a full RX FIFO SHALL both succeed with no overrun; the same applies to push and pop on a full TX FIFO.
REQ-031 proc_ready_out and proc_valid_out SHALL reflect FIFO occupancy one cycle after the push or pop edge (registered counts); no combinational path from proc_*_in to proc_*_out.
REQ-032 clear_err_in coinciding with a new error event SHALL leave that flag set (set wins).
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be a log2(FIFO_DEPTH)+1-bit count.

Reset
REQ-034 While reset=0, both FSMs SHALL be IDLE, FIFOs empty, synchronizer flops 1, uart_tx_out=1, proc_ready_out=1, proc_valid_out=0, proc_data_out=0, and both flags 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately (uart_tx_out=1 asynchronously) with no byte delivered.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-036 Push 0xA5 -> uart_tx_out: low 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then high 4 cycles; proc_ready_out stays 1.
REQ-037 Push 6 bytes in consecutive cycles -> proc_ready_out=0 after the 4th is queued (5th and 6th ignored unless the TX pop already freed a slot); exactly the accepted bytes are transmitted, in order.
REQ-038 Drive 0x3C on uart_rx_in with correct framing -> proc_valid_out=1 and proc_data_out=0x3C; pulse proc_rden_in -> proc_valid_out=0.
REQ-039 Receive 5 bytes without reading -> the first 4 are held in order and rx_overrun_out=1; clear_err_in -> rx_overrun_out=0.
REQ-040 Receive a frame with stop bit 0, then a 1-cycle low glitch -> rx_frame_err_out=1, nothing pushed; the glitch pushes nothing.
REQ-041 Assert reset mid-TX after 3 bits -> uart_tx_out=1 immediately, FIFOs empty, and no residual bits are sent after release.
